// File: rtl/lvds_rx_packer_if.sv
// Bus bundle for the LVDS capture front end: differential inputs from the
// receiver pins, single-ended pass-through taps and the packed word output.
interface lvds_rx_packer_if #(
  parameter int unsigned LVDS_LEN = 8,
  parameter int unsigned DATA_LEN = 32
);

  // Differential pins; [0] = P leg, [1] = N leg for the strobe pair
  logic [LVDS_LEN-1:0] data_p;
  logic [LVDS_LEN-1:0] data_n;
  logic [1:0]          strob;

  // Buffered single-ended taps, combinational
  logic                clk_out;
  logic [LVDS_LEN-1:0] byte_out;
  logic                strob_out;

  // Packed word towards the FIFO/USB stage
  logic [DATA_LEN-1:0] data_out;
  logic                valid_out;

  // Source side: drives the pins, observes the packer outputs
  modport master (
    output data_p,
    output data_n,
    output strob,
    input  clk_out,
    input  byte_out,
    input  strob_out,
    input  data_out,
    input  valid_out
  );

  // Packer side
  modport slave (
    input  data_p,
    input  data_n,
    input  strob,
    output clk_out,
    output byte_out,
    output strob_out,
    output data_out,
    output valid_out
  );

endinterface

// File: rtl/lvds_rx_packer.sv
// LVDS capture front end: differential-to-single-ended buffering of clock,
// strobe and data, then packing of strobe-qualified bytes into little-endian
// words. Bytes seen while the strobe is low are dropped without disturbing
// the partially assembled word.
module lvds_rx_packer #(
  parameter int unsigned LVDS_LEN = 8,
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [1:0]         clk,
  input  logic               rst,
  lvds_rx_packer_if.slave    bus
);

  localparam int unsigned Lanes = DATA_LEN / LVDS_LEN;
  localparam int unsigned CntW  = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(Lanes - 1);

  // ---------------------------------------------------------------------------
  // Differential input buffers. The behavioural model of the IBUFDS-class
  // primitive forwards the P leg; the N legs only matter to the real pad.
  // ---------------------------------------------------------------------------
  logic                clk_se;
  logic                strob_se;
  logic [LVDS_LEN-1:0] byte_se;

  assign clk_se   = clk[0];
  assign strob_se = bus.strob[0];

  // One buffer per data pair
  for (genvar i = 0; i < LVDS_LEN; i++) begin : gen_data_buf
    assign byte_se[i] = bus.data_p[i];
  end

  // N legs are consumed by the pad primitive only
  logic unused_n_legs;
  assign unused_n_legs = ^{clk[1], bus.strob[1], bus.data_n};

  assign bus.clk_out   = clk_se;
  assign bus.strob_out = strob_se;
  assign bus.byte_out  = byte_se;

  // ---------------------------------------------------------------------------
  // Packer state
  // ---------------------------------------------------------------------------
  logic [CntW-1:0]     cnt_q,   cnt_d;
  logic [DATA_LEN-1:0] acc_q,   acc_d;
  logic [DATA_LEN-1:0] data_q,  data_d;
  logic                valid_q, valid_d;

  // Next-state: drop a strobed byte into its lane, publish on the last lane
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (strob_se) begin
      acc_d[LVDS_LEN*int'(cnt_q) +: LVDS_LEN] = byte_se;
      if (cnt_q == LastLane) begin
        // Word complete: current byte lands in the top lane of the output
        data_d  = acc_d;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; async reset throws away any partial word
  always_ff @(posedge clk_se or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_lvds_rx_packer.sv
// Self-checking bench for lvds_rx_packer: a byte-queue reference model is
// compared against the DUT on every falling edge, plus literal word checks.
module tb_lvds_rx_packer;

  logic       clk_p = 1'b0;
  logic [1:0] clk;
  logic       rst;

  assign clk = {~clk_p, clk_p};
  always #5 clk_p = ~clk_p;

  lvds_rx_packer_if #(.LVDS_LEN(8), .DATA_LEN(32)) bus ();

  lvds_rx_packer #(.LVDS_LEN(8), .DATA_LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Collects valid bytes; every fourth one forms a little-endian word.
  logic [7:0]  pend[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data  = '0;

  always @(posedge clk_p or posedge rst) begin
    if (rst) begin
      pend.delete();
      exp_valid <= 1'b0;
      exp_data  <= '0;
    end else if (bus.strob[0] && pend.size() == 3) begin
      exp_data  <= {bus.data_p, pend[2], pend[1], pend[0]};
      exp_valid <= 1'b1;
      pend.delete();
    end else begin
      if (bus.strob[0]) pend.push_back(bus.data_p);
      exp_valid <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] got[$];
  bit          cmp_en = 1'b0;

  always @(negedge clk_p) begin
    if (cmp_en) begin
      chk("valid_out", {31'd0, bus.valid_out}, {31'd0, exp_valid});
      chk("data_out", bus.data_out, exp_data);
      if (bus.valid_out === 1'b1) got.push_back(bus.data_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge; returns after the next falling edge.
  task automatic send(input logic [7:0] b);
    bus.data_p = b;
    bus.data_n = ~b;
    bus.strob  = 2'b01;
    @(negedge clk_p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.data_p = 8'hFF;
      bus.data_n = 8'h00;
      bus.strob  = 2'b10;
      @(negedge clk_p);
    end
  endtask

  task automatic chk_count(input string name, input int exp);
    chk(name, 32'(got.size()), 32'(exp));
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] exp);
    if (idx < got.size()) chk(name, got[idx], exp);
    else chk(name, 32'hxxxx_xxxx, exp);
  endtask

  logic [7:0] stream[$];

  initial begin
    rst        = 1'b1;
    bus.data_p = 8'hFF;
    bus.data_n = 8'h00;
    bus.strob  = 2'b10;

    // Pass-through while held in reset: no capture can happen
    @(negedge clk_p);
    bus.data_p = 8'h5A;
    bus.data_n = 8'hA5;
    bus.strob  = 2'b01;
    #1;
    chk("byte_out_pass", {24'd0, bus.byte_out}, 32'h0000_005A);
    chk("strob_out_hi", {31'd0, bus.strob_out}, 32'd1);
    chk("clk_out_pass", {31'd0, bus.clk_out}, {31'd0, clk_p});
    bus.strob = 2'b10;
    #1;
    chk("strob_out_lo", {31'd0, bus.strob_out}, 32'd0);

    // Reset: four cycles held
    idle(4);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    cmp_en = 1'b1;
    rst    = 1'b0;

    // Basic word
    got.delete();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(3);
    chk_count("basic_count", 1);
    chk_word("basic_word", 0, 32'h4433_2211);

    // Gap inside a word
    got.delete();
    send(8'hAA); send(8'hBB);
    idle(16);
    chk_count("gap_no_pulse", 0);
    send(8'hCC); send(8'hDD);
    idle(3);
    chk_count("gap_count", 1);
    chk_word("gap_word", 0, 32'hDDCC_BBAA);

    // Continuous stream
    got.delete();
    for (int i = 0; i < 12; i++) send(8'(i));
    idle(3);
    chk_count("cont_count", 3);
    chk_word("cont_w0", 0, 32'h0302_0100);
    chk_word("cont_w1", 1, 32'h0706_0504);
    chk_word("cont_w2", 2, 32'h0B0A_0908);

    // Mid-word reset discards partial word
    got.delete();
    send(8'h01); send(8'h02);
    rst = 1'b1;
    idle(2);
    chk("midrst_data", bus.data_out, 32'h0);
    rst = 1'b0;
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    idle(3);
    chk_count("midrst_count", 1);
    chk_word("midrst_word", 0, 32'h0807_0605);

    // Long stream: 3402 samples with 16-cycle FF pauses
    got.delete();
    stream.delete();
    for (int i = 0; i < 3402; i++) begin
      logic [7:0] b;
      b = 8'((i * 37 + 11) ^ (i >> 3));
      stream.push_back(b);
      send(b);
      if (i % 53 == 52) idle(16);
    end
    idle(4);
    chk_count("long_count", 3402 / 4);
    for (int k = 0; k < 3402 / 4; k++) begin
      if (k < got.size() && got[k] !== {stream[4*k+3], stream[4*k+2], stream[4*k+1],
                                        stream[4*k]}) begin
        chk("long_word", got[k], {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]});
      end
    end
    chk_word("long_last", 3402 / 4 - 1,
             {stream[3399], stream[3398], stream[3397], stream[3396]});

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
